// File: rtl/nonoverlap_pkg.sv
// nonoverlap_pkg
//   Shared types and helpers for the dead-time generator.
//   - nonovl_state_t : per-channel FSM state encoding
//   - CNT_W_DEF      : default dead-time counter width
//   - illegal()      : shoot-through request detect (both FET commands high)
package nonoverlap_pkg;

    typedef enum logic [1:0] {
        OFF,
        DEAD,
        DRIVE
    } nonovl_state_t;

    localparam int CNT_W_DEF = 6;

    function automatic logic illegal(input logic h, input logic l);
        return h & l;
    endfunction

endpackage

// File: rtl/nonoverlap_ch.sv
// nonoverlap_ch
//   One half-bridge channel: dead-time FSM, down-counter, previous-input
//   register and shoot-through fault flag.
//   Optional macro NONOVL_FAULT_LATCH_EN: sticky fault that holds the
//   channel in OFF until fault_clr; otherwise fault is a registered level.
// Ports
//   clk, rst          clock, async active-high reset
//   en                bridge enable (0 forces OFF, outputs 0)
//   dead_time         dead period in clocks, sampled at counter load
//   high_in, low_in   raw FET commands
//   fault_clr         clears the sticky fault (latched build only)
//   high_out, low_out registered, non-overlapped gate commands
//   dead_busy         1 while in the dead period
//   fault             shoot-through flag
//
//   state | meaning
//   OFF   | bridge disabled or fault-held; outputs 0
//   DEAD  | dead period running (or waiting out an illegal input); outputs 0
//   DRIVE | outputs follow inputs every clock
module nonoverlap_ch
    import nonoverlap_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] dead_time,
    input  logic             high_in,
    input  logic             low_in,
    input  logic             fault_clr,
    output logic             high_out,
    output logic             low_out,
    output logic             dead_busy,
    output logic             fault
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    nonovl_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             prev_h, prev_l, prev_h_nxt, prev_l_nxt;
    logic             high_nxt, low_nxt;
    logic             bad, changed, dt_zero, fault_nxt, hold_off;

    assign bad     = illegal(high_in, low_in);
    assign changed = (high_in != prev_h) || (low_in != prev_l);
    assign dt_zero = (dead_time == '0);

`ifdef NONOVL_FAULT_LATCH_EN
    // A clear coinciding with a still-illegal input loses to the set.
    assign fault_nxt = bad | (fault & ~fault_clr);
    assign hold_off  = fault_nxt;
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
    assign fault_nxt = bad;
    assign hold_off  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OFF;
            cnt      <= '0;
            prev_h   <= 1'b0;
            prev_l   <= 1'b0;
            high_out <= 1'b0;
            low_out  <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prev_h   <= prev_h_nxt;
            prev_l   <= prev_l_nxt;
            high_out <= high_nxt;
            low_out  <= low_nxt;
            fault    <= fault_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        prev_h_nxt = prev_h;
        prev_l_nxt = prev_l;
        if (!en || hold_off) begin
            state_nxt = OFF;
        end else if (bad) begin
            // Park in DEAD with prev={1,1}; the first legal input then
            // counts as a change and reloads a full dead period.
            state_nxt  = DEAD;
            cnt_nxt    = dead_time;
            prev_h_nxt = high_in;
            prev_l_nxt = low_in;
        end else begin
            case (state)
                OFF: begin
                    prev_h_nxt = high_in;
                    prev_l_nxt = low_in;
                    cnt_nxt    = dead_time;
                    state_nxt  = dt_zero ? DRIVE : DEAD;
                end
                DEAD: begin
                    if (changed) begin
                        prev_h_nxt = high_in;
                        prev_l_nxt = low_in;
                        cnt_nxt    = dead_time;
                        state_nxt  = dt_zero ? DRIVE : DEAD;
                    end else if (cnt <= CNT_ONE) begin
                        state_nxt = DRIVE;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                DRIVE: begin
                    prev_h_nxt = high_in;
                    prev_l_nxt = low_in;
                    if (changed && !dt_zero) begin
                        cnt_nxt   = dead_time;
                        state_nxt = DEAD;
                    end
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    // Output logic: DRIVE is never entered on an illegal input, so the
    // registered outputs can never both be high.
    always_comb begin
        high_nxt = 1'b0;
        low_nxt  = 1'b0;
        if (state_nxt == DRIVE) begin
            high_nxt = high_in;
            low_nxt  = low_in;
        end
    end

    assign dead_busy = (state == DEAD);

endmodule

// File: rtl/nonoverlap_mc.sv
// nonoverlap_mc
//   Multi-channel programmable dead-time generator for motor-drive
//   half-bridges. NUM_CH independent channels share en, dead_time and
//   fault_clr. Optional macro NONOVL_FAULT_LATCH_EN selects sticky faults.
// Ports
//   clk, rst          clock, async active-high reset
//   en                bridge enable
//   dead_time         shared dead period in clocks
//   high_in, low_in   raw FET commands per channel
//   fault_clr         sticky-fault clear
//   high_out, low_out non-overlapped gate commands per channel
//   dead_busy         per-channel dead-period indicator
//   fault             per-channel shoot-through flag
module nonoverlap_mc
    import nonoverlap_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  dead_time,
    input  logic [NUM_CH-1:0] high_in,
    input  logic [NUM_CH-1:0] low_in,
    input  logic              fault_clr,
    output logic [NUM_CH-1:0] high_out,
    output logic [NUM_CH-1:0] low_out,
    output logic [NUM_CH-1:0] dead_busy,
    output logic [NUM_CH-1:0] fault
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nonoverlap_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .dead_time(dead_time),
            .high_in  (high_in[i]),
            .low_in   (low_in[i]),
            .fault_clr(fault_clr),
            .high_out (high_out[i]),
            .low_out  (low_out[i]),
            .dead_busy(dead_busy[i]),
            .fault    (fault[i])
        );
    end

endmodule

// File: tb/tb_nonoverlap_mc.sv
module tb_nonoverlap_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [5:0] dead_time = 6'd0;
    logic [2:0] high_in = 3'b000;
    logic [2:0] low_in = 3'b000;
    logic       fault_clr = 1'b0;
    logic [2:0] high_out, low_out, dead_busy, fault;

    int vectors = 0;
    int miscompares = 0;

    nonoverlap_mc #(.NUM_CH(3), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dead_time(dead_time),
        .high_in  (high_in),
        .low_in   (low_in),
        .fault_clr(fault_clr),
        .high_out (high_out),
        .low_out  (low_out),
        .dead_busy(dead_busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({high_out, low_out, dead_busy, fault} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got h=%b l=%b b=%b f=%b, want all 0", high_out, low_out, dead_busy, fault);
        end
        tick();
        tick();
        vectors++;
        if ({high_out, low_out, dead_busy} !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_held: got h=%b l=%b b=%b, want all 0", high_out, low_out, dead_busy);
        end
        rst = 1'b0;
        en = 1'b1;
        dead_time = 6'd4;
        tick();
        vectors++;
        if (dead_busy !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_exit_dead: got busy=%b, want 111", dead_busy);
        end
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (dead_busy !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_exit_drive: got busy=%b, want 000", dead_busy);
        end
    endtask

    task automatic test_dead_basic();
        low_in[0] = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            vectors++;
            if (low_out[0] !== (k >= 4) || dead_busy[0] !== (k < 4) || high_out[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL dead_basic k=%0d: got l=%b b=%b h=%b, want l=%b b=%b h=0",
                         k, low_out[0], dead_busy[0], high_out[0], k >= 4, k < 4);
            end
        end
    endtask

    task automatic test_swap_d8();
        dead_time = 6'd8;
        high_in[0] = 1'b1;
        low_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (high_out[0] !== 1'b1 || low_out[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_setup: got h=%b l=%b, want h=1 l=0", high_out[0], low_out[0]);
        end
        high_in[0] = 1'b0;
        low_in[0] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            vectors++;
            if (high_out[0] !== 1'b0 || low_out[0] !== (k >= 8) || (high_out & low_out) !== 3'b000) begin
                miscompares++;
                $display("FAIL swap_d8 k=%0d: got h=%b l=%b, want h=0 l=%b no overlap",
                         k, high_out[0], low_out[0], k >= 8);
            end
        end
    endtask

    task automatic test_restart();
        dead_time = 6'd6;
        high_in[0] = 1'b1;
        low_in[0] = 1'b0;
        tick();
        tick();
        tick();
        high_in[0] = 1'b0;
        low_in[0] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            vectors++;
            if (high_out[0] !== 1'b0 || low_out[0] !== (k >= 6) || dead_busy[0] !== (k < 6)) begin
                miscompares++;
                $display("FAIL restart k=%0d: got h=%b l=%b b=%b, want h=0 l=%b b=%b",
                         k, high_out[0], low_out[0], dead_busy[0], k >= 6, k < 6);
            end
        end
    endtask

    task automatic test_zero_dead();
        logic [2:0] hv [6];
        logic [2:0] lv [6];
        hv = '{3'b001, 3'b100, 3'b000, 3'b111, 3'b010, 3'b000};
        lv = '{3'b010, 3'b011, 3'b111, 3'b000, 3'b101, 3'b000};
        dead_time = 6'd0;
        for (int i = 0; i < 6; i++) begin
            high_in = hv[i];
            low_in = lv[i];
            tick();
            vectors++;
            if (high_out !== hv[i] || low_out !== lv[i] || dead_busy !== 3'b000) begin
                miscompares++;
                $display("FAIL zero_dead v=%0d: got h=%b l=%b b=%b, want h=%b l=%b b=000",
                         i, high_out, low_out, dead_busy, hv[i], lv[i]);
            end
        end
    endtask

    task automatic test_shoot_through();
        dead_time = 6'd4;
        tick();
        high_in[1] = 1'b1;
        low_in[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (fault !== 3'b010 || high_out[1] !== 1'b0 || low_out[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL shoot_flag k=%0d: got f=%b h1=%b l1=%b, want f=010 h1=0 l1=0",
                         k, fault, high_out[1], low_out[1]);
            end
        end
`ifdef NONOVL_FAULT_LATCH_EN
        fault_clr = 1'b1;
        tick();
        vectors++;
        if (fault !== 3'b010 || dead_busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL shoot_set_wins: got f=%b b1=%b, want f=010 b1=0", fault, dead_busy[1]);
        end
        fault_clr = 1'b0;
        low_in[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (fault !== 3'b010 || high_out[1] !== 1'b0 || dead_busy[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL shoot_sticky k=%0d: got f=%b h1=%b b1=%b, want f=010 h1=0 b1=0",
                         k, fault, high_out[1], dead_busy[1]);
            end
        end
        fault_clr = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            fault_clr = 1'b0;
            vectors++;
            if (fault !== 3'b000 || high_out[1] !== (k >= 4) || dead_busy[1] !== (k < 4)) begin
                miscompares++;
                $display("FAIL shoot_recover k=%0d: got f=%b h1=%b b1=%b, want f=000 h1=%b b1=%b",
                         k, fault, high_out[1], dead_busy[1], k >= 4, k < 4);
            end
        end
`else
        low_in[1] = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            tick();
            vectors++;
            if (fault !== 3'b000 || high_out[1] !== (k >= 4) || dead_busy[1] !== (k < 4)) begin
                miscompares++;
                $display("FAIL shoot_recover k=%0d: got f=%b h1=%b b1=%b, want f=000 h1=%b b1=%b",
                         k, fault, high_out[1], dead_busy[1], k >= 4, k < 4);
            end
        end
`endif
    endtask

    task automatic check_turn_on(input string tag);
        for (int k = 0; k <= 4; k++) begin
            tick();
            vectors++;
            if (high_out !== ((k >= 4) ? 3'b010 : 3'b000) || low_out !== ((k >= 4) ? 3'b001 : 3'b000) ||
                dead_busy !== ((k < 4) ? 3'b111 : 3'b000)) begin
                miscompares++;
                $display("FAIL %s k=%0d: got h=%b l=%b b=%b, want h=%b l=%b b=%b", tag, k,
                         high_out, low_out, dead_busy, (k >= 4) ? 3'b010 : 3'b000,
                         (k >= 4) ? 3'b001 : 3'b000, (k < 4) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_disable_reset();
        low_in[0] = 1'b1;
        tick();
        tick();
        en = 1'b0;
        tick();
        vectors++;
        if (high_out !== 3'b000 || low_out !== 3'b000 || dead_busy !== 3'b000) begin
            miscompares++;
            $display("FAIL disable: got h=%b l=%b b=%b, want all 0", high_out, low_out, dead_busy);
        end
        en = 1'b1;
        check_turn_on("enable_dead");
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (high_out !== 3'b000 || low_out !== 3'b000 || dead_busy !== 3'b000 || fault !== 3'b000) begin
            miscompares++;
            $display("FAIL async_rst: got h=%b l=%b b=%b f=%b, want all 0", high_out, low_out, dead_busy, fault);
        end
        #1;
        rst = 1'b0;
        check_turn_on("rst_exit_dead");
    endtask

    initial begin
        test_reset();
        test_dead_basic();
        test_swap_d8();
        test_restart();
        test_zero_dead();
        test_shoot_through();
        test_disable_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
